// File: rtl/hist_pkg.sv
// -----------------------------------------------------------------------------
// hist_pkg
// Shared constants and the FSM state type for the grey statistics stage.
// There are no ports. This package holds the gain constants and the state
// encoding used by hist_minmax_scale.
// -----------------------------------------------------------------------------
package hist_pkg;

    localparam int unsigned GRAY_W  = 8;
    localparam int unsigned SCALE_W = 16;

    localparam logic [GRAY_W-1:0]  FULL_SCALE = 8'd255;
    localparam logic [SCALE_W-1:0] UNITY_GAIN = 16'h0100;
    localparam logic [SCALE_W-1:0] SAT_GAIN   = 16'hFFFF;

    // Stretch numerator: full-scale grey expressed in Q8.8 (255 << 8).
    localparam logic [SCALE_W-1:0] STRETCH_NUM = {FULL_SCALE, 8'h00};

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        PUBLISH
    } state_t;

endpackage : hist_pkg

// File: rtl/hist_serial_div.sv
// -----------------------------------------------------------------------------
// hist_serial_div
// Restoring unsigned divider. It produces one quotient bit per cycle, MSB
// first, and takes NUM_W cycles per divide.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   start       accepted only while idle; num/den are sampled with it
//   num, den    dividend (NUM_W bits) and divisor (DEN_W bits, must be nonzero)
//   last_c      high during the final iteration cycle (combinational)
//   done        1-cycle pulse in the cycle after the final iteration
//   quot        quotient; valid while done is high
// -----------------------------------------------------------------------------
module hist_serial_div #(
    parameter int unsigned NUM_W = 16,
    parameter int unsigned DEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             last_c,
    output logic             done,
    output logic [NUM_W-1:0] quot
);

    localparam int unsigned CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] den_r;
    logic [DEN_W:0]   trial_c;
    logic             fits_c;

    // The dividend is shifted out of quot's MSB while quotient bits enter at the LSB.
    assign trial_c = {rem, quot[NUM_W-1]};
    assign fits_c  = (trial_c >= {1'b0, den_r});
    assign last_c  = active && (cnt == CNT_W'(NUM_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
            rem    <= '0;
            den_r  <= '0;
            quot   <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (start) begin
                    active <= 1'b1;
                    cnt    <= '0;
                    rem    <= '0;
                    den_r  <= den;
                    quot   <= num;
                end
            end else begin
                // Remainder stays below den_r, so the restored value always fits DEN_W bits.
                rem  <= fits_c ? DEN_W'(trial_c - {1'b0, den_r}) : DEN_W'(trial_c);
                quot <= {quot[NUM_W-2:0], fits_c};
                cnt  <= cnt + CNT_W'(1);
                if (last_c) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule : hist_serial_div

// File: rtl/hist_minmax_scale.sv
// -----------------------------------------------------------------------------
// hist_minmax_scale
// Per-frame grey min/max tracker. At frame end it computes the stretch gain
// floor(255*256/(max-min)) in Q8.8 with a serial divider, then publishes
// {gray_max, gray_min, scale} together.
// Ports:
//   pixelclk, reset      clock and synchronous active-high reset
//   din                  grey sample, qualified by i_de
//   i_hsync              line sync; not used internally
//   i_vsync              frame sync; a rising edge starts a frame, a falling edge ends it
//   i_de                 active-pixel qualifier
//   gray_max, gray_min   published frame extremes
//   scale                published Q8.8 gain (0xFFFF for a zero-range frame)
//   stats_valid          1-cycle pulse in the first cycle new values are visible
//   busy                 high while a divide is in flight
//   frame_drop           1-cycle pulse when a frame result is discarded
// -----------------------------------------------------------------------------
module hist_minmax_scale #(
    parameter int unsigned DW      = 8,
    parameter int unsigned SCALE_W = 16
) (
    input  logic               pixelclk,
    input  logic               reset,
    input  logic [DW-1:0]      din,
    input  logic               i_hsync,
    input  logic               i_vsync,
    input  logic               i_de,
    output logic [DW-1:0]      gray_max,
    output logic [DW-1:0]      gray_min,
    output logic [SCALE_W-1:0] scale,
    output logic               stats_valid,
    output logic               busy,
    output logic               frame_drop
);

    import hist_pkg::*;

    logic               vsync_r;
    logic               fs_c;
    logic               fe_c;
    logic [DW-1:0]      run_min;
    logic [DW-1:0]      run_max;
    logic [DW-1:0]      snap_min;
    logic [DW-1:0]      snap_max;
    state_t             state;
    logic               div_start_c;
    logic               div_last_c;
    logic               div_done;
    logic [SCALE_W-1:0] div_quot;
    logic               unused_hsync;

    assign unused_hsync = i_hsync;

    // Frame edges come from the registered vsync.
    assign fs_c = i_vsync & ~vsync_r;
    assign fe_c = ~i_vsync & vsync_r;

    // Launch a divide only for a frame with a nonzero range, and only when idle.
    assign div_start_c = (state == IDLE) && fe_c && (run_max > run_min);

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            vsync_r <= 1'b0;
        end else begin
            vsync_r <= i_vsync;
        end
    end

    // Running extremes. They run independently of the divide and restart on every frame start.
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            run_min <= '1;
            run_max <= '0;
        end else if (fs_c) begin
            run_min <= i_de ? din : '1;
            run_max <= i_de ? din : '0;
        end else if (i_de) begin
            run_min <= (din < run_min) ? din : run_min;
            run_max <= (din > run_max) ? din : run_max;
        end
    end

    hist_serial_div #(
        .NUM_W (SCALE_W),
        .DEN_W (DW)
    ) u_div (
        .clk    (pixelclk),
        .reset  (reset),
        .start  (div_start_c),
        .num    (SCALE_W'(STRETCH_NUM)),
        .den    (run_max - run_min),
        .last_c (div_last_c),
        .done   (div_done),
        .quot   (div_quot)
    );

    // Publish FSM. Outputs change only here, and the three values always move together.
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            state       <= IDLE;
            snap_min    <= '0;
            snap_max    <= '0;
            gray_max    <= '1;
            gray_min    <= '0;
            scale       <= SCALE_W'(UNITY_GAIN);
            stats_valid <= 1'b0;
            busy        <= 1'b0;
            frame_drop  <= 1'b0;
        end else begin
            stats_valid <= 1'b0;
            frame_drop  <= 1'b0;
            case (state)
                IDLE: begin
                    if (fe_c) begin
                        if (run_max < run_min) begin
                            // No active pixel was seen since the frame start.
                            frame_drop <= 1'b1;
                        end else if (run_max == run_min) begin
                            gray_max    <= run_max;
                            gray_min    <= run_min;
                            scale       <= SCALE_W'(SAT_GAIN);
                            stats_valid <= 1'b1;
                        end else begin
                            snap_min <= run_min;
                            snap_max <= run_max;
                            busy     <= 1'b1;
                            state    <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (fe_c) begin
                        frame_drop <= 1'b1;
                    end
                    if (div_last_c) begin
                        state <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    if (fe_c) begin
                        frame_drop <= 1'b1;
                    end
                    if (div_done) begin
                        gray_max    <= snap_max;
                        gray_min    <= snap_min;
                        scale       <= div_quot;
                        stats_valid <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : hist_minmax_scale
